bus_timer_slave: RTL and testbench
==================================

Name: bus_timer_slave

Overview:
- Bus responder (slave) for the shared CPU bus that sits behind the bus arbiter, alongside the BRAM and UART slaves.
- Implements a memory-mapped programmable timer with a one-shot or periodic mode, an expiry flag and an interrupt output.
- Uses the same slave-side signal set the arbiter drives: chip enable, address strobe, write enable, address, write data and byte select. It returns read data and ready.
- The arbiter does address decode and asserts ce for this slave. The block uses only addr[4:2].

Parameters:
- CNT_W, 32: width of the COUNT and LIMIT registers, 1..32. Reads zero-extend to 32 bits.
- LIMIT_RST, 32'hFFFF_FFFF: reset value of LIMIT, truncated to CNT_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- ce  input  1  slave select from the arbiter.
- as  input  1  address strobe. A request is ce & as.
- we_in  input  1  1 = write, 0 = read.
- addr  input  32  byte address. Only addr[4:2] is decoded.
- wr_data  input  32  write data.
- byte_sel  input  4  byte enables for writes. Bit i enables wr_data[8i+7:8i].
- rd_data  output  32  read data, valid while ready = 1.
- ready  output  1  one-cycle access-complete pulse.
- irq  output  1  level interrupt, registered.

Behaviour:
- Reset (rst = 0 at a clk edge) sets: rd_data = 0, ready = 0, irq = 0, CTRL = 0, COUNT = 0, STATUS = 0, LIMIT = LIMIT_RST, FSM = IDLE, prescale counter = 0.
- Register map (addr[4:2]):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN. Other bits read 0.
  - 1 LIMIT.
  - 2 COUNT: a read returns the live value, a write loads it.
  - 3 STATUS: bit0 EXPIRED. Writing 1 to bit0 with byte_sel[0] = 1 clears it (W1C).
  - 4 PRESCALE: only with the optional feature.
  - All others read 0; writes are ignored, and ready is still returned.
- Bus handshake FSM:
  - IDLE: if ce & as at an edge, commit the write or latch rd_data, assert ready at that same edge, and go to ACK.
  - ACK: deassert ready, clear rd_data to 0, and go to IDLE unconditionally. The request is not re-sampled in ACK.
  - Fixed latency: ready is high in the cycle after the request is sampled. Master signals must stay stable until ready.
  - A back-to-back request is accepted no earlier than 2 cycles after the previous one.
- Byte-sel writes: only enabled bytes are updated. Bits at or above CNT_W are dropped.
- Counting:
  - A tick occurs every cycle while EN = 1; with the prescaler, every PRESCALE+1 cycles.
  - On a tick, if COUNT == LIMIT:
    - set EXPIRED;
    - if PERIODIC = 1, COUNT <= 0;
    - otherwise COUNT holds and EN <= 0.
  - Otherwise COUNT <= COUNT + 1, wrapping mod 2^CNT_W.
  - Expiry is the compare; wrap happens only if LIMIT was lowered below COUNT.
- LIMIT = 0 in periodic mode: EXPIRED is set on every tick and COUNT stays 0.
- irq is registered: irq <= EXPIRED & IRQ_EN, so it lags EXPIRED by 1 cycle.
- Simultaneous events:
  - A bus write to COUNT beats a tick increment or reload in the same cycle.
  - A bus write to CTRL.EN beats a one-shot auto-clear.
  - A hardware EXPIRED set beats a W1C clear in the same cycle.
- Reset asserted mid-access: FSM returns to IDLE and ready = 0 next cycle; the access is dropped with no ready.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- Defined: adds a 16-bit PRESCALE register at addr[4:2] = 4, reset value 0, byte-sel writable, readable. An internal 16-bit divider generates a tick when it equals PRESCALE, then restarts at 0. Writing CTRL or PRESCALE resets the divider to 0.
- Not defined: there is no divider, a tick occurs every enabled cycle, and address 0x10 reads 0 with writes ignored.

Test Plan:
- Reset, then read LIMIT (0x04) -> ready exactly 1 cycle after the request, rd_data = 32'hFFFF_FFFF. Then read CTRL -> 0, irq = 0.
- Write LIMIT = 3, then CTRL = 0x5 (EN, IRQ_EN, one-shot) -> COUNT reads 3 after expiry, STATUS = 1, CTRL.EN reads 0, and irq rises 1 cycle after EXPIRED.
- Periodic mode: LIMIT = 2, CTRL = 0x3 -> COUNT sequence 0,1,2,0,1,2 and EXPIRED set at the first 2→0 reload. Write STATUS = 1 -> bit0 reads 0 unless it coincides with an expiry tick, in which case it reads 1.
- Byte select: write COUNT = 32'hAABBCCDD with byte_sel = 4'b0010 while EN = 0 -> COUNT reads 32'h0000CC00. A write to addr 0x1C -> ready pulse, reads 0.
- Hold ce & as high for 4 cycles with a read -> exactly 2 ready pulses (cycles 2 and 4). Pull rst low during ACK -> ready = 0 next cycle.
- With TIMER_PRESCALER_EN: PRESCALE = 3, LIMIT = 1, periodic -> EXPIRED first set 8 cycles after EN is written.

Source files
------------

// File: rtl/bus_timer_slave.sv
// Memory-mapped programmable timer slave (one-shot/periodic, expiry flag, irq).
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module bus_timer_slave #(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] LIMIT_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        as,
  input  logic        we_in,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  byte_sel,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        irq
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               irq_q, irq_d;
  logic               en_q, en_d;
  logic               periodic_q, periodic_d;
  logic               irq_en_q, irq_en_d;
  logic               expired_q, expired_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   count_q, count_d;
`ifdef TIMER_PRESCALER_EN
  logic [15:0]        presc_q, presc_d;
  logic [15:0]        div_q, div_d;
`endif

  logic        accept, wr_acc, rd_acc, tick, exp_set, exp_clr;
  logic [2:0]  sel;
  logic [31:0] rd_val, count_ext, limit_ext;

  logic unused_addr;
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  // Byte-enable merge for counter-width registers; bits at or above CNT_W never exist.
  function automatic logic [CNT_W-1:0] merge_cnt(input logic [CNT_W-1:0] old_v,
                                                  input logic [31:0] data,
                                                  input logic [3:0] be);
    logic [CNT_W-1:0] res;
    for (int i = 0; i < CNT_W; i++) res[i] = be[i/8] ? data[i] : old_v[i];
    return res;
  endfunction

  assign sel    = addr[4:2];
  assign accept = (state_q == S_IDLE) && ce && as;
  assign wr_acc = accept && we_in;
  assign rd_acc = accept && !we_in;

  always_comb begin
    count_ext = '0;
    limit_ext = '0;
    count_ext[CNT_W-1:0] = count_q;
    limit_ext[CNT_W-1:0] = limit_q;
    rd_val = '0;
    case (sel)
      3'd0: rd_val = {29'd0, irq_en_q, periodic_q, en_q};
      3'd1: rd_val = limit_ext;
      3'd2: rd_val = count_ext;
      3'd3: rd_val = {31'd0, expired_q};
`ifdef TIMER_PRESCALER_EN
      3'd4: rd_val = {16'd0, presc_q};
`endif
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    rd_data_d  = '0;
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    limit_d    = limit_q;
    count_d    = count_q;
    exp_set    = 1'b0;
    exp_clr    = 1'b0;
`ifdef TIMER_PRESCALER_EN
    presc_d = presc_q;
    div_d   = div_q;
    tick    = en_q && (div_q == presc_q);
    if (en_q) div_d = tick ? 16'd0 : div_q + 16'd1;
`else
    tick = en_q;
`endif

    if (tick) begin
      if (count_q == limit_q) begin
        exp_set = 1'b1;
        if (periodic_q) count_d = '0;
        else            en_d    = 1'b0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    // Bus writes are applied last so they override the timer's own updates.
    if (wr_acc) begin
      case (sel)
        3'd0: begin
          if (byte_sel[0]) {irq_en_d, periodic_d, en_d} = wr_data[2:0];
`ifdef TIMER_PRESCALER_EN
          div_d = 16'd0;
`endif
        end
        3'd1: limit_d = merge_cnt(limit_q, wr_data, byte_sel);
        3'd2: count_d = merge_cnt(count_q, wr_data, byte_sel);
        3'd3: exp_clr = byte_sel[0] && wr_data[0];
`ifdef TIMER_PRESCALER_EN
        3'd4: begin
          for (int i = 0; i < 16; i++)
            presc_d[i] = byte_sel[i/8] ? wr_data[i] : presc_q[i];
          div_d = 16'd0;
        end
`endif
        default: ;
      endcase
    end

    expired_d = (expired_q && !exp_clr) || exp_set;
    irq_d     = expired_q && irq_en_q;

    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_ACK;
        ready_d = 1'b1;
        if (rd_acc) rd_data_d = rd_val;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      limit_q    <= LIMIT_RST[CNT_W-1:0];
      count_q    <= '0;
`ifdef TIMER_PRESCALER_EN
      presc_q    <= '0;
      div_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      expired_q  <= expired_d;
      limit_q    <= limit_d;
      count_q    <= count_d;
`ifdef TIMER_PRESCALER_EN
      presc_q    <= presc_d;
      div_q      <= div_d;
`endif
    end
  end

  assign rd_data = rd_data_q;
  assign ready   = ready_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed testbench for bus_timer_slave: register access, one-shot/periodic timing,
// W1C priority, byte selects, handshake spacing and reset during an access.
module tb_bus_timer_slave;

  logic        clk = 1'b0;
  logic        rst, ce, as, we_in;
  logic [31:0] addr, wr_data, rd_data;
  logic [3:0]  byte_sel;
  logic        ready, irq;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_timer_slave dut (
    .clk(clk), .rst(rst), .ce(ce), .as(as), .we_in(we_in), .addr(addr),
    .wr_data(wr_data), .byte_sel(byte_sel), .rd_data(rd_data), .ready(ready), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete access: request sampled at the next edge, ACK on the following one.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd);
    ce = 1'b1; as = 1'b1; we_in = w; addr = a; wr_data = d; byte_sel = be;
    cyc();
    check("ready_pulse", {31'd0, ready}, 32'd1);
    rd = rd_data;
    ce = 1'b0; as = 1'b0; we_in = 1'b0;
    cyc();
    check("ready_drop", {31'd0, ready}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] dummy;
    bus(1'b1, a, d, be, dummy);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'd0, 4'd0, v);
    check(tag, v, exp);
  endtask

  initial begin
    logic [31:0] per_exp [6];
    int pulses;
    per_exp = '{32'd1, 32'd0, 32'd2, 32'd1, 32'd0, 32'd2};

    rst = 1'b0; ce = 1'b0; as = 1'b0; we_in = 1'b0;
    addr = '0; wr_data = '0; byte_sel = '0;
    cyc(); cyc();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    cyc();

    rd("limit_rst", 32'h04, 32'hFFFF_FFFF);
    rd("ctrl_rst", 32'h00, 32'h0);
    check("irq_idle", {31'd0, irq}, 32'd0);

    // One-shot: LIMIT=3, EN|IRQ_EN. Expiry at W+4, irq at W+5.
    wr(32'h04, 32'd3, 4'hF);
    wr(32'h00, 32'h5, 4'hF);
    cyc(); cyc(); cyc();
    check("oneshot_irq_lag", {31'd0, irq}, 32'd0);
    cyc();
    check("oneshot_irq_rise", {31'd0, irq}, 32'd1);
    rd("oneshot_count", 32'h08, 32'd3);
    rd("oneshot_status", 32'h0C, 32'd1);
    rd("oneshot_ctrl", 32'h00, 32'h4);
    wr(32'h0C, 32'd1, 4'h1);
    rd("w1c_status", 32'h0C, 32'd0);
    check("w1c_irq_low", {31'd0, irq}, 32'd0);
    wr(32'h00, 32'h0, 4'hF);

    // Periodic, LIMIT=2: reads every 2 cycles see 1,0,2,1,0,2.
    wr(32'h08, 32'd0, 4'hF);
    wr(32'h04, 32'd2, 4'hF);
    wr(32'h00, 32'h3, 4'hF);
    for (int i = 0; i < 6; i++) rd("periodic_count", 32'h08, per_exp[i]);
    rd("periodic_status", 32'h0C, 32'd1);

    // LIMIT=0 periodic: expiry every tick, a W1C loses to the simultaneous set.
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h08, 32'd0, 4'hF);
    wr(32'h04, 32'd0, 4'hF);
    wr(32'h00, 32'h7, 4'hF);
    cyc();
    check("lim0_irq", {31'd0, irq}, 32'd1);
    wr(32'h0C, 32'd1, 4'h1);
    check("set_beats_w1c", {31'd0, irq}, 32'd1);
    rd("lim0_count", 32'h08, 32'd0);
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h0C, 32'd1, 4'h1);
    rd("w1c_idle_status", 32'h0C, 32'd0);
    check("irq_off", {31'd0, irq}, 32'd0);

    // Byte selects and unmapped addresses.
    wr(32'h08, 32'd0, 4'hF);
    wr(32'h08, 32'hAABB_CCDD, 4'b0010);
    rd("bytesel_count", 32'h08, 32'h0000_CC00);
    wr(32'h04, 32'h1234_5678, 4'b1001);
    rd("bytesel_limit", 32'h04, 32'h1200_0078);
    wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
    rd("unmapped_1c", 32'h1C, 32'd0);
    rd("addr_10_rst", 32'h10, 32'd0);

    // Request held for 4 cycles: ready on 1st and 3rd edge only.
    pulses = 0;
    ce = 1'b1; as = 1'b1; we_in = 1'b0; addr = 32'h04;
    cyc(); pulses += int'(ready);
    check("hold_rd1", rd_data, 32'h1200_0078);
    cyc(); pulses += int'(ready);
    check("hold_ack_rd", rd_data, 32'd0);
    cyc(); pulses += int'(ready);
    check("hold_ready3", {31'd0, ready}, 32'd1);
    cyc(); pulses += int'(ready);
    check("hold_pulses", pulses, 32'd2);
    ce = 1'b0; as = 1'b0;
    cyc();

    // Reset in ACK, then reset coinciding with a request.
    ce = 1'b1; as = 1'b1; addr = 32'h04;
    cyc();
    check("pre_rst_ready", {31'd0, ready}, 32'd1);
    ce = 1'b0; as = 1'b0; rst = 1'b0;
    cyc();
    check("rst_ack_ready", {31'd0, ready}, 32'd0);
    check("rst_ack_rd", rd_data, 32'd0);
    ce = 1'b1; as = 1'b1;
    cyc();
    check("rst_req_dropped", {31'd0, ready}, 32'd0);
    ce = 1'b0; as = 1'b0; rst = 1'b1;
    cyc();
    rd("limit_after_rst", 32'h04, 32'hFFFF_FFFF);
    rd("count_after_rst", 32'h08, 32'd0);

`ifdef TIMER_PRESCALER_EN
    // PRESCALE=3, LIMIT=1 periodic: expiry at W+8, irq at W+9.
    wr(32'h04, 32'd1, 4'hF);
    wr(32'h10, 32'd3, 4'hF);
    rd("presc_rd", 32'h10, 32'd3);
    wr(32'h00, 32'h7, 4'hF);
    for (int i = 0; i < 7; i++) cyc();
    check("presc_irq_lag", {31'd0, irq}, 32'd0);
    cyc();
    check("presc_irq_rise", {31'd0, irq}, 32'd1);
`else
    wr(32'h10, 32'd3, 4'hF);
    rd("addr_10_ignored", 32'h10, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
